// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-shift sequencer: shifts a latched operand by up to STEP positions per clock
// and presents the result through a valid/ready handshake.
module shift_sequencer #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpSll  = 2'b00;
  localparam logic [1:0] OpSra  = 2'b11;
  localparam logic [1:0] OpRsvd = 2'b10;
  localparam logic [4:0] StepAmt = 5'(STEP);

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  rem_q, rem_d;
  logic [1:0]  op_q, op_d;
  logic        fill_q, fill_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic [4:0]  step_amt;
  logic [63:0] wide_right;
  logic [31:0] shifted;

  always_comb begin
    step_amt   = (rem_q < StepAmt) ? rem_q : StepAmt;
    // Right shifts pull the fill bit in from a 64-bit extension; fill is 0 for SRL.
    wide_right = {{32{fill_q}}, acc_q} >> step_amt;
    shifted    = (op_q == OpSll) ? (acc_q << step_amt) : wide_right[31:0];

    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    fill_d  = fill_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d   = op;
          fill_d = (op == OpSra) & a[31];
          acc_d  = a;
          if ((shamt == 5'd0) || (op == OpRsvd)) begin
            rem_d   = 5'd0;
            state_d = StDone;
          end else begin
            rem_d   = shamt;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        acc_d = shifted;
        rem_d = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= 32'd0;
      rem_q       <= 5'd0;
      op_q        <= 2'b00;
      fill_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      fill_q      <= fill_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: three instances (STEP 4, 1, 16) share stimulus; each has
// its own expected-result queue and monitor that checks result and latency on every output.
module tb_shift_sequencer;

  localparam int NumDut = 3;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic        out_ready = 1'b1;

  logic        in_ready  [NumDut];
  logic        out_valid [NumDut];
  logic        busy      [NumDut];
  logic [31:0] result    [NumDut];

  exp_t exp_q [NumDut][$];
  int   cycle = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic int step_of(int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
  endfunction

  function automatic void check(string name, int g, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s dut%0d (STEP=%0d): got %h, expected %h", name, g, step_of(g), act, req);
  endfunction

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    shift_sequencer #(
      .STEP(g == 0 ? 4 : (g == 1 ? 1 : 16))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready[g]),
      .op       (op),
      .a        (a),
      .shamt    (shamt),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .result   (result[g]),
      .busy     (busy[g])
    );

    logic prev_valid = 1'b0;
    exp_t e;

    // Each rising out_valid is one presented result; pop and compare it.
    always @(negedge clk) begin
      if (out_valid[g] && !prev_valid) begin
        if (exp_q[g].size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output dut%0d: got result %h, expected no output", g,
                   result[g]);
        end else begin
          e = exp_q[g].pop_front();
          check("result", g, result[g], e.res);
          check("latency", g, 32'(cycle - e.acc_cycle), 32'(e.lat));
        end
      end
      prev_valid <= out_valid[g];
    end
  end

  function automatic logic all_ready();
    logic r = 1'b1;
    for (int i = 0; i < NumDut; i++) r &= in_ready[i];
    return r;
  endfunction

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (all_ready()) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL idle_timeout: in_ready not all high within 200 cycles, expected high");
    end
  endtask

  // Issue one request to all instances and scramble the inputs right after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [4:0] s,
                       input logic [31:0] exp_res);
    logic ok;
    exp_t e;
    wait_idle(ok);
    if (!ok) return;
    op = o;
    a = va;
    shamt = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NumDut; i++) begin
      e.res = exp_res;
      e.lat = (o == 2'b10 || s == 5'd0) ? 0 : (int'(s) + step_of(i) - 1) / step_of(i);
      e.acc_cycle = cycle;
      exp_q[i].push_back(e);
    end
    in_valid = 1'b0;
    a = ~va ^ 32'h5A5A_A5A5;
    shamt = ~s;
    op = ~o;
  endtask

  task automatic wait_out0(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL out_valid_timeout: dut0 out_valid low after 100 cycles, expected high");
    end
  endtask

  initial begin
    logic ok;
    logic [31:0] srl_val;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NumDut; i++) begin
      check("reset_in_ready", i, 32'(in_ready[i]), 32'd1);
      check("reset_out_valid", i, 32'(out_valid[i]), 32'd0);
      check("reset_busy", i, 32'(busy[i]), 32'd0);
      check("reset_result", i, result[i], 32'd0);
    end
    reset = 1'b0;

    // SRL sweep of the MSB
    srl_val = 32'h8000_0000;
    for (int s = 0; s < 32; s++) begin
      issue(2'b01, 32'h8000_0000, 5'(s), srl_val);
      srl_val = {1'b0, srl_val[31:1]};
    end

    issue(2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000);
    issue(2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    issue(2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001);
    issue(2'b10, 32'h1234_5678, 5'd7,  32'h1234_5678);
    issue(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
    issue(2'b11, 32'h7FFF_FFFF, 5'd3,  32'h0FFF_FFFF);
    issue(2'b00, 32'hDEAD_BEEF, 5'd5,  32'hD5B7_DDE0);
    issue(2'b11, 32'hF0F0_F0F0, 5'd9,  32'hFFF8_7878);
    issue(2'b01, 32'hF0F0_F0F0, 5'd17, 32'h0000_7878);

    // Backpressure: hold out_ready low in DONE while in_valid and a wiggle.
    wait_idle(ok);
    out_ready = 1'b0;
    issue(2'b11, 32'h8000_0000, 5'd4, 32'hF800_0000);
    wait_out0(ok);
    if (ok) begin
      for (int n = 0; n < 5; n++) begin
        in_valid = n[0];
        a = 32'h1111_1111 * (n + 1);
        shamt = 5'd1;
        op = 2'b00;
        @(negedge clk);
        check("bp_out_valid", 0, 32'(out_valid[0]), 32'd1);
        check("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
        check("bp_result", 0, result[0], 32'hF800_0000);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset mid-operation: the SRL by 31 must vanish without an output.
    wait_idle(ok);
    op = 2'b01;
    a = 32'h8000_0000;
    shamt = 5'd31;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NumDut; i++) begin
      check("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
      check("rst_busy", i, 32'(busy[i]), 32'd0);
      check("rst_in_ready", i, 32'(in_ready[i]), 32'd1);
      check("rst_result", i, result[i], 32'd0);
    end
    issue(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);

    wait_idle(ok);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NumDut; i++) begin
      check("queue_drained", i, 32'(exp_q[i].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
